// File: rtl/timer_pkg.sv
// Shared constants for the BCD timer blocks.
//   BCD_UNIT_MAX : largest units digit (9)
//   BCD_TENS_MAX : largest tens digit for a modulo-60 count (5)
//   BCD_ZERO     : digit reset / wrap target
package timer_pkg;
  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_ZERO     = 4'd0;

  // Clamp a raw 4-bit digit to [0, lim].
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction
endpackage

// File: rtl/timer60_bcd_digit_counter.sv
// Single BCD digit counter with load, enable and up/down direction.
// Ports:
//   clk, rst       : rising-edge clock, async active-high reset (value -> 0)
//   load, ld_val   : synchronous load of ld_val (caller guarantees range)
//   en, up         : step enable and direction (1 = up)
//   max            : largest value of this digit
//   value          : registered digit
//   wrap           : combinational, high when the step taken this cycle wraps
//                    (max->0 up, 0->max down)
module bcd_digit_counter
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       en,
  input  logic       up,
  input  logic [3:0] max,
  output logic [3:0] value,
  output logic       wrap
);
  logic [3:0] value_q, value_d;
  logic       at_edge;

  always_comb begin
    // >= rather than == so an out-of-range value still falls back into range
    at_edge = up ? (value_q >= max) : (value_q == BCD_ZERO);
    wrap    = en & at_edge;
    value_d = value_q;
    if (load)
      value_d = ld_val;
    else if (en) begin
      if (up) value_d = at_edge ? BCD_ZERO : value_q + 4'd1;
      else    value_d = at_edge ? max      : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= BCD_ZERO;
    else     value_q <= value_d;
  end

  assign value = value_q;
endmodule

// File: rtl/timer60.sv
// Two-digit BCD modulo-60 counter (00..59) with load, up/down, start/pause/stop
// gating and registered wrap carry pulses. carry60[1] rising edge is usable
// as the clock of a cascaded instance (seconds -> minutes).
// Ports:
//   Clk, reset        : rising-edge clock, async active-high reset
//   set_time          : load init digits (only while start=0, stop=0)
//   UpOrDown          : 1 = up, 0 = down
//   start/pause/stop  : count enable, temporary freeze, terminal freeze
//   Init_unitvalue    : init units digit (clamped to 9)
//   Init_dozenvalue   : init tens digit (clamped to 5)
//   Init_value60      : combinational {Init_dozenvalue, Init_unitvalue}
//   Count60           : registered {tens, units}
//   carry60           : [0] units wrap pulse, [1] full 60 wrap pulse
module timer60
  import timer_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic       set_time,
  input  logic       UpOrDown,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [3:0] Init_unitvalue,
  input  logic [3:0] Init_dozenvalue,
  output logic [7:0] Init_value60,
  output logic [7:0] Count60,
  output logic [1:0] carry60
);
  logic       step, load;
  logic       unit_wrap, tens_wrap;
  logic [3:0] units, tens;
  logic [1:0] carry_q, carry_d;

  // stop dominates everything; start blocks loading even when paused
  assign step = ~stop & start & ~pause;
  assign load = ~stop & ~start & set_time;

  assign Init_value60 = {Init_dozenvalue, Init_unitvalue};

  bcd_digit_counter u_units (
    .clk    (Clk),
    .rst    (reset),
    .load   (load),
    .ld_val (bcd_clamp(Init_unitvalue, BCD_UNIT_MAX)),
    .en     (step),
    .up     (UpOrDown),
    .max    (BCD_UNIT_MAX),
    .value  (units),
    .wrap   (unit_wrap)
  );

  // tens only moves when the units digit wraps, so its wrap is the full 60 wrap
  bcd_digit_counter u_tens (
    .clk    (Clk),
    .rst    (reset),
    .load   (load),
    .ld_val (bcd_clamp(Init_dozenvalue, BCD_TENS_MAX)),
    .en     (unit_wrap),
    .up     (UpOrDown),
    .max    (BCD_TENS_MAX),
    .value  (tens),
    .wrap   (tens_wrap)
  );

  assign carry_d = {tens_wrap, unit_wrap};

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) carry_q <= 2'b00;
    else       carry_q <= carry_d;
  end

  assign Count60 = {tens, units};
  assign carry60 = carry_q;
endmodule

// File: tb/tb_timer60.sv
module tb_timer60;
  logic       Clk = 0, reset = 1;
  logic       set_time = 0, UpOrDown = 1, start = 0, stop = 0, pause = 0;
  logic [3:0] Init_unitvalue = 0, Init_dozenvalue = 0;
  logic [7:0] Init_value60, Count60;
  logic [1:0] carry60;

  timer60 dut (
    .Clk(Clk), .reset(reset), .set_time(set_time), .UpOrDown(UpOrDown),
    .start(start), .stop(stop), .pause(pause),
    .Init_unitvalue(Init_unitvalue), .Init_dozenvalue(Init_dozenvalue),
    .Init_value60(Init_value60), .Count60(Count60), .carry60(carry60)
  );

  always #5 Clk = ~Clk;

  int cmp = 0, bad = 0;

  // Behavioural model: count held as an integer 0..59.
  int         m_cnt = 0;
  logic [1:0] m_carry = 0;
  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_carry = 0;
    end else begin
      m_carry = 0;
      if (stop) ;
      else if (!start && set_time)
        m_cnt = 10 * (Init_dozenvalue > 5 ? 5 : int'(Init_dozenvalue))
              + (Init_unitvalue > 9 ? 9 : int'(Init_unitvalue));
      else if (start && !pause) begin
        if (UpOrDown) begin
          m_carry = {m_cnt == 59, m_cnt % 10 == 9};
          m_cnt = (m_cnt + 1) % 60;
        end else begin
          m_carry = {m_cnt == 0, m_cnt % 10 == 0};
          m_cnt = (m_cnt + 59) % 60;
        end
      end
    end
  end

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10); u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, 1 time unit after each edge.
  bit chk_en = 0;
  always @(posedge Clk) begin
    #1;
    if (chk_en) begin
      chk("model_count", Count60, bcd(m_cnt));
      chk("model_carry", {6'd0, carry60}, {6'd0, m_carry});
      chk("model_init", Init_value60, {Init_dozenvalue, Init_unitvalue});
    end
  end

  task automatic load(input logic [3:0] d, input logic [3:0] u);
    start = 0; set_time = 1; Init_dozenvalue = d; Init_unitvalue = u;
    @(negedge Clk);
    set_time = 0;
  endtask

  task automatic edge_chk(input string name, input logic [7:0] c, input logic [1:0] cy);
    @(negedge Clk);
    chk({name, "_cnt"}, Count60, c);
    chk({name, "_cy"}, {6'd0, carry60}, {6'd0, cy});
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk("reset_cnt", Count60, 8'h00);
    chk("reset_cy", {6'd0, carry60}, 8'h00);
    reset = 0;
    chk_en = 1;

    // 1: load 42
    load(4'd4, 4'd2);
    chk("load42_cnt", Count60, 8'h42);
    chk("load42_init", Init_value60, 8'h42);

    // 2: down from 10
    load(4'd1, 4'd0);
    start = 1; UpOrDown = 0;
    edge_chk("dn09", 8'h09, 2'b01);
    edge_chk("dn08", 8'h08, 2'b00);
    edge_chk("dn07", 8'h07, 2'b00);

    // 3: down wrap 00 -> 59
    load(4'd0, 4'd0);
    start = 1; UpOrDown = 0;
    edge_chk("dn59", 8'h59, 2'b11);
    edge_chk("dn58", 8'h58, 2'b00);

    // 4: up wrap 59 -> 00
    load(4'd5, 4'd8);
    start = 1; UpOrDown = 1;
    edge_chk("up59", 8'h59, 2'b00);
    edge_chk("up00", 8'h00, 2'b11);

    // 5: pause / stop / load-ignored
    load(4'd3, 4'd0);
    start = 1; UpOrDown = 0;
    edge_chk("r29", 8'h29, 2'b01);
    edge_chk("r28", 8'h28, 2'b00);
    pause = 1;
    repeat (5) edge_chk("pause", 8'h28, 2'b00);
    pause = 0; set_time = 1; Init_dozenvalue = 4'd1; Init_unitvalue = 4'd2;
    edge_chk("noload", 8'h27, 2'b00);
    set_time = 0; stop = 1;
    repeat (3) edge_chk("stop", 8'h27, 2'b00);
    stop = 0;
    edge_chk("resume", 8'h26, 2'b00);

    // 6: clamp, then async reset between edges
    load(4'd7, 4'd12);
    chk("clamp", Count60, 8'h59);
    start = 1; UpOrDown = 1;
    edge_chk("clamp_up", 8'h00, 2'b11);
    @(posedge Clk); #3;
    reset = 1; #1;
    chk("async_rst_cnt", Count60, 8'h00);
    chk("async_rst_cy", {6'd0, carry60}, 8'h00);
    @(negedge Clk); reset = 0;

    // Random phase
    repeat (3000) begin
      @(negedge Clk);
      reset           = ($urandom_range(0, 99) == 0);
      start           = ($urandom_range(0, 3) != 0);
      set_time        = ($urandom_range(0, 3) == 0);
      pause           = ($urandom_range(0, 7) == 0);
      stop            = ($urandom_range(0, 15) == 0);
      UpOrDown        = ($urandom_range(0, 31) == 0) ? ~UpOrDown : UpOrDown;
      Init_unitvalue  = 4'($urandom_range(0, 15));
      Init_dozenvalue = 4'($urandom_range(0, 15));
    end
    @(negedge Clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
